// File: rtl/reg_op_sequencer_pkg.sv
// Shared definitions for the register-operation sequencer.
// Holds the opcode encodings used by the FSM and the ALU, and the FSM state encoding.
// Imported by seq_alu and reg_op_sequencer.
package reg_op_sequencer_pkg;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_op_sequencer_seq_alu.sv
// Purpose : combinational ALU for the sequencer (result, carry/borrow, zero).
// Latency : purely combinational, zero cycles.
// Ports   : i_op opcode, i_op_a/i_op_b operands, i_imm immediate; o_result, o_carry, o_zero.
module seq_alu
  import reg_op_sequencer_pkg::*;
#(
  parameter int DataBusWidth = 8
) (
  input  logic [2:0]              i_op,
  input  logic [DataBusWidth-1:0] i_op_a,
  input  logic [DataBusWidth-1:0] i_op_b,
  input  logic [DataBusWidth-1:0] i_imm,
  output logic [DataBusWidth-1:0] o_result,
  output logic                    o_carry,
  output logic                    o_zero
);

  // One extra bit on both: MSB of the sum is carry-out, MSB of the difference is borrow.
  logic [DataBusWidth:0] w_sum;
  logic [DataBusWidth:0] w_diff;

  assign w_sum  = {1'b0, i_op_a} + {1'b0, i_op_b};
  assign w_diff = {1'b0, i_op_a} - {1'b0, i_op_b};

  always_comb begin
    o_result = i_op_a;
    o_carry  = 1'b0;
    case (i_op)
      OP_MOV: o_result = i_op_a;
      OP_ADD: begin
        o_result = w_sum[DataBusWidth-1:0];
        o_carry  = w_sum[DataBusWidth];
      end
      OP_SUB, OP_CMP: begin
        o_result = w_diff[DataBusWidth-1:0];
        o_carry  = w_diff[DataBusWidth];
      end
      OP_AND: o_result = i_op_a & i_op_b;
      OP_OR:  o_result = i_op_a | i_op_b;
      OP_XOR: o_result = i_op_a ^ i_op_b;
      OP_LDI: o_result = i_imm;
      default: o_result = i_op_a;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Purpose : four-state sequencer executing one register-file instruction (IDLE/READ/EXEC/WB).
// Latency : write-back (done/load) in the 3rd cycle after the handshake; one instruction per 4 cycles.
// Ports   : in_valid/in_ready instruction handshake with op/rd/rs1/rs2/imm; a1/a2 -> rdData1/rdData2
//           register-file reads; aWrite/dataOut/load register-file write; done pulse; carry/zero flags.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int AddrBusWidth = 3,
  parameter int DataBusWidth = 8
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [AddrBusWidth-1:0] rd,
  input  logic [AddrBusWidth-1:0] rs1,
  input  logic [AddrBusWidth-1:0] rs2,
  input  logic [DataBusWidth-1:0] imm,
  output logic [AddrBusWidth-1:0] a1,
  output logic [AddrBusWidth-1:0] a2,
  input  logic [DataBusWidth-1:0] rdData1,
  input  logic [DataBusWidth-1:0] rdData2,
  output logic [AddrBusWidth-1:0] aWrite,
  output logic [DataBusWidth-1:0] dataOut,
  output logic                    load,
  output logic                    done,
  output logic                    carry,
  output logic                    zero
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_fire;
  logic [2:0]              r_op;
  logic [AddrBusWidth-1:0] r_rd;
  logic [AddrBusWidth-1:0] r_a1;
  logic [AddrBusWidth-1:0] r_a2;
  logic [DataBusWidth-1:0] r_imm;
  logic [DataBusWidth-1:0] r_op_a;
  logic [DataBusWidth-1:0] r_op_b;
  logic [DataBusWidth-1:0] r_result;
  logic                    r_carry;
  logic                    r_zero;
  logic [DataBusWidth-1:0] w_alu_result;
  logic                    w_alu_carry;
  logic                    w_alu_zero;

  // Gating with nRst keeps in_ready low while reset is asserted even though the state is IDLE.
  assign in_ready = (r_state == ST_IDLE) && nRst;
  assign w_fire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // load/done decode straight from state so an async reset removes them in the same instant.
  always_comb begin
    w_state_nxt = r_state;
    load        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (w_fire) w_state_nxt = ST_READ;
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_state_nxt = ST_IDLE;
        done        = 1'b1;
        load        = (r_op != OP_CMP);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_imm    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_op  <= op;
        r_rd  <= rd;
        r_a1  <= rs1;
        r_a2  <= rs2;
        r_imm <= imm;
      end
      // Operands are taken here, before any write-back, so rd == rs1/rs2 reads the old value.
      if (r_state == ST_READ) begin
        r_op_a <= rdData1;
        r_op_b <= rdData2;
      end
      // Flags only move on the EXEC edge and hold through WB and IDLE.
      if (r_state == ST_EXEC) begin
        r_result <= w_alu_result;
        r_carry  <= w_alu_carry;
        r_zero   <= w_alu_zero;
      end
    end
  end

  seq_alu #(
    .DataBusWidth(DataBusWidth)
  ) u_seq_alu (
    .i_op    (r_op),
    .i_op_a  (r_op_a),
    .i_op_b  (r_op_b),
    .i_imm   (r_imm),
    .o_result(w_alu_result),
    .o_carry (w_alu_carry),
    .o_zero  (w_alu_zero)
  );

  assign a1      = r_a1;
  assign a2      = r_a2;
  assign aWrite  = r_rd;
  assign dataOut = r_result;
  assign carry   = r_carry;
  assign zero    = r_zero;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a small behavioural register file.
// Instructions are driven on the falling edge, outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_reg_op_sequencer;
  import reg_op_sequencer_pkg::*;

  logic       clk;
  logic       nRst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [2:0] rd;
  logic [2:0] rs1;
  logic [2:0] rs2;
  logic [7:0] imm;
  logic [2:0] a1;
  logic [2:0] a2;
  logic [7:0] rdData1;
  logic [7:0] rdData2;
  logic [2:0] aWrite;
  logic [7:0] dataOut;
  logic       load;
  logic       done;
  logic       carry;
  logic       zero;

  logic [7:0] rf [0:7];

  int n_cmp = 0;
  int n_err = 0;

  logic       wb_load;
  logic       wb_done;
  logic [2:0] wb_awrite;
  logic [7:0] wb_data;
  logic       wb_carry;
  logic       wb_zero;

  reg_op_sequencer #(
    .AddrBusWidth(3),
    .DataBusWidth(8)
  ) dut (
    .clk     (clk),
    .nRst    (nRst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op      (op),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .a1      (a1),
    .a2      (a2),
    .rdData1 (rdData1),
    .rdData2 (rdData2),
    .aWrite  (aWrite),
    .dataOut (dataOut),
    .load    (load),
    .done    (done),
    .carry   (carry),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write on the rising edge when load is high.
  assign rdData1 = rf[a1];
  assign rdData2 = rf[a2];
  always @(posedge clk) begin
    if (load) rf[aWrite] <= dataOut;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one instruction and returns at the falling edge inside WB with the outputs captured.
  task automatic run(input logic [2:0] op_i, input logic [2:0] rd_i, input logic [2:0] rs1_i,
                     input logic [2:0] rs2_i, input logic [7:0] imm_i);
    @(negedge clk);
    op = op_i; rd = rd_i; rs1 = rs1_i; rs2 = rs2_i; imm = imm_i;
    in_valid = 1'b1;
    #1;
    chk("idle_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("read_a1", a1, rs1_i);
    chk("read_a2", a2, rs2_i);
    chk("read_ctl", {in_ready, done, load}, 3'b000);
    @(negedge clk);
    chk("exec_ctl", {in_ready, done, load}, 3'b000);
    @(negedge clk);
    wb_load   = load;
    wb_done   = done;
    wb_awrite = aWrite;
    wb_data   = dataOut;
    wb_carry  = carry;
    wb_zero   = zero;
    chk("wb_ready", in_ready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; in_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {in_ready, a1, a2, aWrite, dataOut, load, done, carry, zero}, 0);
    nRst = 1'b1;
    #1;
    chk("rst_rel_ready", in_ready, 1);

    // LDI rd=3 imm=0x5A
    run(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h5A);
    chk("ldi_done", wb_done, 1);
    chk("ldi_load", wb_load, 1);
    chk("ldi_awr", wb_awrite, 3);
    chk("ldi_data", wb_data, 8'h5A);
    chk("ldi_flags", {wb_carry, wb_zero}, 2'b00);
    @(negedge clk);
    chk("ldi_rf3", rf[3], 8'h5A);
    chk("idle_ctl", {done, load}, 2'b00);

    // Preload operands
    run(OP_LDI, 3'd0, 3'd0, 3'd0, 8'h01);
    run(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hF0);
    run(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h20);
    run(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h33);
    run(OP_LDI, 3'd6, 3'd0, 3'd0, 8'h33);
    run(OP_LDI, 3'd7, 3'd0, 3'd0, 8'h02);

    // ADD 0xF0 + 0x20 -> 0x10, carry
    run(OP_ADD, 3'd4, 3'd1, 3'd2, 8'h00);
    chk("add_data", wb_data, 8'h10);
    chk("add_awr", wb_awrite, 4);
    chk("add_flags", {wb_carry, wb_zero}, 2'b10);
    @(negedge clk);
    chk("add_rf4", rf[4], 8'h10);
    chk("add_hold", {carry, zero}, 2'b10);

    // CMP equal -> zero, no write-back
    run(OP_CMP, 3'd7, 3'd5, 3'd6, 8'h00);
    chk("cmp_done_load", {wb_done, wb_load}, 2'b10);
    chk("cmp_flags", {wb_carry, wb_zero}, 2'b01);
    @(negedge clk);
    chk("cmp_rf7", rf[7], 8'h02);

    // SUB 0x01 - 0x02 -> 0xFF with borrow, rd == rs1
    run(OP_SUB, 3'd0, 3'd0, 3'd7, 8'h00);
    chk("sub_data", wb_data, 8'hFF);
    chk("sub_flags", {wb_carry, wb_zero}, 2'b10);
    @(negedge clk);
    chk("sub_rf0", rf[0], 8'hFF);

    // AND 0xF0 & 0x10
    run(OP_AND, 3'd6, 3'd1, 3'd4, 8'h00);
    chk("and_data", wb_data, 8'h10);
    chk("and_flags", {wb_carry, wb_zero}, 2'b00);

    // XOR r2 with itself after loading 0xAA
    run(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hAA);
    run(OP_XOR, 3'd2, 3'd2, 3'd2, 8'h00);
    chk("xor_data", wb_data, 8'h00);
    chk("xor_flags", {wb_carry, wb_zero}, 2'b01);
    @(negedge clk);
    chk("xor_rf2", rf[2], 8'h00);

    // Back-to-back: in_valid held high for three OR instructions (0xF0 | 0x10)
    @(negedge clk);
    op = OP_OR; rd = 3'd3; rs1 = 3'd1; rs2 = 3'd4; imm = 8'h00;
    in_valid = 1'b1;
    begin
      int hs;
      hs = 0;
      for (int k = 0; k < 12; k++) begin
        if (k > 0) @(negedge clk);
        #1;
        if (in_ready && in_valid) hs++;
        chk("b2b_ready", in_ready, (k % 4 == 0) ? 1 : 0);
        chk("b2b_done", done, (k % 4 == 3) ? 1 : 0);
        if (k % 4 == 3) chk("b2b_data", dataOut, 8'hF0);
        if (k == 11) in_valid = 1'b0;
      end
      chk("b2b_handshakes", hs, 3);
    end
    @(negedge clk);
    chk("b2b_rf3", rf[3], 8'hF0);

    // Reset in the middle of an ADD write-back: 0xF0 + 0x10 into r7
    run(OP_ADD, 3'd7, 3'd1, 3'd4, 8'h00);
    chk("rstwb_load_pre", wb_load, 1);
    #2;
    nRst = 1'b0;
    #1;
    chk("rstwb_outs", {in_ready, a1, a2, aWrite, dataOut, load, done, carry, zero}, 0);
    @(negedge clk);
    chk("rstwb_rf7", rf[7], 8'h02);
    nRst = 1'b1;
    #1;
    chk("rstwb_ready", in_ready, 1);

    // Machine still works after the aborted instruction
    run(OP_MOV, 3'd5, 3'd1, 3'd0, 8'h00);
    chk("mov_data", wb_data, 8'hF0);
    chk("mov_load", wb_load, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter AddrBusWidth, default 3, register address width.
REQ-002 Parameter DataBusWidth, default 8, register data width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 nRst  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  sequencer can accept an instruction.
REQ-007 op  input  3  opcode: 0 MOV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 CMP.
REQ-008 rd, rs1, rs2  input  AddrBusWidth each  destination and source register numbers.
REQ-009 imm  input  DataBusWidth  immediate for LDI.
REQ-010 a1, a2  output  AddrBusWidth each  register-file read addresses.
REQ-011 rdData1, rdData2  input  DataBusWidth each  register-file read data; combinational from a1/a2.
REQ-012 aWrite  output  AddrBusWidth  register-file write address.
REQ-013 dataOut  output  DataBusWidth  register-file write data.
REQ-014 load  output  1  register-file write enable, sampled by the register file on clk.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 carry, zero  output  1 each  status flags of the last executed instruction.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, EXEC, WB.
REQ-018 in_ready SHALL be 1 only in IDLE with nRst high; the handshake completes on an edge where in_valid and in_ready are both 1.
REQ-019 On handshake edge N: latch op, rd, rs1, rs2, imm; drive a1=rs1, a2=rs2 (registered); IDLE->READ.
REQ-020 Edge N+1: capture rdData1 into opA and rdData2 into opB; READ->EXEC.
REQ-021 Edge N+2: register result, carry, zero; EXEC->WB.
REQ-022 In the WB cycle (between edges N+2 and N+3): done=1, aWrite=rd, dataOut=result, load=1 except for CMP (load=0); edge N+3 WB->IDLE.
REQ-023 Throughput SHALL be one instruction per 4 cycles; in_valid is ignored outside IDLE.
REQ-024 Results: MOV=opA; ADD=opA+opB; SUB=opA-opB; AND/OR/XOR bitwise; LDI=imm; CMP=opA-opB (not written back). All arithmetic is modulo 2^DataBusWidth.
REQ-025 carry: ADD = carry-out of the (DataBusWidth+1)-bit sum; SUB/CMP = borrow (1 when opA<opB unsigned); all other ops = 0.
REQ-026 zero SHALL be 1 when the result is all zeros, including CMP.
REQ-027 carry and zero SHALL hold their value until the next EXEC edge.
REQ-028 rd equal to rs1 or rs2 SHALL be legal; operands are those read in READ, before write-back.
REQ-029 load and done SHALL never be 1 outside WB.

Reset
REQ-030 nRst low SHALL immediately force state IDLE and a1=a2=aWrite=0, dataOut=0, load=0, done=0, carry=0, zero=0, in_ready=0.
REQ-031 Reset in any state SHALL abort the instruction with no load pulse; after nRst rises the first handshake is possible on the next edge.

Structure
REQ-032 A shared package SHALL hold opcode constants (MOV..CMP) and the FSM state encoding.
REQ-033 The combinational arithmetic (REQ-024..026) SHALL be a sub-module named seq_alu; the FSM and registers stay in reg_op_sequencer.

Verification
REQ-034 Reset mid-WB of an ADD -> load drops immediately, all outputs 0, register file unchanged.
REQ-035 LDI rd=3 imm=0x5A -> load=1, aWrite=3, dataOut=0x5A, done=1 exactly 3 cycles after handshake; carry=0, zero=0.
REQ-036 ADD with r1=0xF0, r2=0x20, rd=4 -> dataOut=0x10, carry=1, zero=0.
REQ-037 CMP with r1=0x33, r2=0x33 -> load=0, done=1, zero=1, carry=0; SUB 0x01-0x02 -> dataOut=0xFF, carry=1.
REQ-038 in_valid held high for 3 back-to-back instructions -> handshakes exactly 4 cycles apart, in_ready low in READ/EXEC/WB.
REQ-039 XOR rd=rs1=rs2=2 with r2=0xAA -> dataOut=0x00, zero=1, r2 becomes 0x00 after WB.
